// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates pipe_ena, drains on HALT, parks in DONE.
// Optional enabled-cycle counter built only when PIPE_RUN_CTRL_CYCLE_CNT_EN is defined.
//
// state | meaning
// IDLE  | after reset, pipeline frozen, waiting for run/step
// RUN   | free-running, watching IF for the HALT opcode
// STEP  | single enabled cycle, then back to PAUSE
// PAUSE | frozen but resumable via run/step
// DRAIN | fetch killed, in-flight instructions retiring
// DONE  | parked; only reset leaves
module pipeline_run_ctrl #(
    parameter int          PIPE_DEPTH  = 5,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [31:0]      instr_IF,
    output logic             pipe_ena,
    output logic             fetch_kill,
    output logic [2:0]       state_o,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_PAUSE = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               halt_at_if;
    logic               unused_instr;

    assign halt_at_if   = (instr_IF[31:26] == HALT_OPCODE);
    assign unused_instr = ^instr_IF[25:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if ((state_q != S_DRAIN) && (state_d == S_DRAIN)) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state_q == S_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (run_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_at_if) begin
                    state_d = S_DRAIN;
                end else if (halt_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_STEP: begin
                state_d = halt_at_if ? S_DRAIN : S_PAUSE;
            end
            S_DRAIN: begin
                // <= 1 also covers a degenerate single-stage pipe loading zero
                if (drain_cnt <= DRAIN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_ena   = 1'b0;
        fetch_kill = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        state_o    = state_q;
        case (state_q)
            S_RUN, S_STEP: begin
                pipe_ena = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                pipe_ena   = 1'b1;
                fetch_kill = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                halted = 1'b1;
            end
            default: begin
                pipe_ena = 1'b0;
            end
        endcase
    end

`ifdef PIPE_RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // saturating: a long free-run must never wrap back to small values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (pipe_ena && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule
